// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and size derivations for the time-multiplexed
//                convolution neuron and its window generator.
//                  state_e    - neuron FSM states (LOAD, DRAIN, OUT)
//                  calc_n     - window element count CIN*F*F
//                  calc_beats - beats per window, ceil(N/LANES)
//                  calc_acc_w - accumulator/result width
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

  function automatic int calc_n(input int cin, input int f);
    return cin * f * f;
  endfunction

  function automatic int calc_beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  // Product is 2*width; summing n of them plus a 2*width bias needs
  // clog2(n+1) growth bits.
  function automatic int calc_acc_w(input int width, input int n);
    return 2 * width + $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane_sum.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lane_sum
//  Description : LANES signed multipliers feeding an adder reduction, with
//                the beat's partial sum registered together with its
//                valid/first/last tags.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                in_valid         - a beat is being accepted this cycle
//                in_first/in_last - beat is the first/last of its window
//                lane_en          - per-lane enable; disabled lanes add 0
//                weights, data    - LANES packed signed WIDTH operands
//                psum_valid/first/last, psum - registered partial sum
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_lane_sum #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 5,
  parameter int PSUM_W = 2 * WIDTH + $clog2(LANES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [LANES-1:0]           lane_en,
  input  logic [LANES*WIDTH-1:0]     weights,
  input  logic [LANES*WIDTH-1:0]     data,
  output logic                       psum_valid,
  output logic                       psum_first,
  output logic                       psum_last,
  output logic signed [PSUM_W-1:0]   psum
);

  logic signed [2*WIDTH-1:0] w_mul  [LANES];
  logic signed [2*WIDTH-1:0] w_prod [LANES];
  logic signed [PSUM_W-1:0]  w_sum;

  logic                      r_valid;
  logic                      r_first;
  logic                      r_last;
  logic signed [PSUM_W-1:0]  r_psum;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      // Operands are sign-extended to full product width before multiplying.
      assign w_mul[k]  = (2*WIDTH)'($signed(weights[k*WIDTH +: WIDTH]))
                       * (2*WIDTH)'($signed(data[k*WIDTH +: WIDTH]));
      // Masking after the multiply keeps the select free of signedness mixing.
      assign w_prod[k] = lane_en[k] ? w_mul[k] : '0;
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sum = w_sum + PSUM_W'(w_prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_psum  <= '0;
    end else begin
      r_valid <= in_valid;
      r_first <= in_valid && in_first;
      r_last  <= in_valid && in_last;
      if (in_valid) begin
        r_psum <= w_sum;
      end
    end
  end

  assign psum_valid = r_valid;
  assign psum_first = r_first;
  assign psum_last  = r_last;
  assign psum       = r_psum;

endmodule
`default_nettype wire

// File: rtl/conv_neuron_seq.sv
`default_nettype none
// ============================================================================
//  Module      : conv_neuron_seq
//  Description : Time-multiplexed convolution neuron. Computes
//                ReLU(bias + sum w[i]*x[i]) over a CIN*F*F window streamed in
//                LANES elements per beat, with runtime-writable weights/bias.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                w_we/w_addr/w_data  - weight write (ignored while w_busy)
//                b_we/b_data         - bias write (ignored while w_busy)
//                w_busy              - window in flight
//                relu_bypass         - sampled on beat 0; 1 = raw sum out
//                in_valid/in_ready/in_data   - beat stream
//                out_valid/out_ready/z       - result handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_neuron_seq
  import conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int F     = 5,
  parameter int CIN   = 3,
  parameter int LANES = 5,
  parameter int ACC_W = calc_acc_w(WIDTH, calc_n(CIN, F))
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              w_we,
  input  logic [$clog2(calc_n(CIN, F))-1:0] w_addr,
  input  logic [WIDTH-1:0]                  w_data,
  input  logic                              b_we,
  input  logic [2*WIDTH-1:0]                b_data,
  output logic                              w_busy,
  input  logic                              relu_bypass,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*WIDTH-1:0]            in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [ACC_W-1:0]           z
);

  localparam int N      = calc_n(CIN, F);
  localparam int BEATS  = calc_beats(N, LANES);
  localparam int AW     = $clog2(N);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW     = $clog2(BEATS * LANES + 1);
  localparam int PSUM_W = 2 * WIDTH + $clog2(LANES + 1);

  // Parameter store: not reset, contents survive rst.
  logic [WIDTH-1:0]           r_w [N];
  logic signed [2*WIDTH-1:0]  r_bias;

  state_e                     r_state;
  logic [BW-1:0]              r_beat_cnt;
  logic                       r_bypass;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_acc_last;
  logic signed [ACC_W-1:0]    r_z;

  logic                       w_accept;
  logic                       w_first;
  logic                       w_last;
  logic [LANES-1:0]           w_lane_en;
  logic [LANES*WIDTH-1:0]     w_lane_w;
  logic signed [ACC_W-1:0]    w_relu;

  logic                       m_valid;
  logic                       m_first;
  logic                       m_last;
  logic signed [PSUM_W-1:0]   m_psum;

  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == OUT);
  assign z         = r_z;
  // Busy from the first accepted beat (counter leaves 0) until LOAD re-entry.
  assign w_busy    = (r_state != LOAD) || (r_beat_cnt != '0);

  assign w_accept  = in_valid && in_ready;
  assign w_first   = (r_beat_cnt == '0);
  assign w_last    = (r_beat_cnt == BW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (w_we && !w_busy && (int'(w_addr) < N)) begin
      r_w[w_addr] <= w_data;
    end
    if (b_we && !w_busy) begin
      r_bias <= b_data;
    end
  end

  // Weight slice for the current beat; lanes past the end of the window
  // (last beat when LANES does not divide N) are disabled.
  always_comb begin
    logic [IW-1:0] idx;
    w_lane_w  = '0;
    w_lane_en = '0;
    idx       = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = IW'(r_beat_cnt) * IW'(LANES) + IW'(k);
      if (int'(idx) < N) begin
        w_lane_en[k]               = 1'b1;
        w_lane_w[k*WIDTH +: WIDTH] = r_w[idx[AW-1:0]];
      end
    end
  end

  mac_lane_sum #(
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .PSUM_W (PSUM_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (w_accept),
    .in_first   (w_first),
    .in_last    (w_last),
    .lane_en    (w_lane_en),
    .weights    (w_lane_w),
    .data       (in_data),
    .psum_valid (m_valid),
    .psum_first (m_first),
    .psum_last  (m_last),
    .psum       (m_psum)
  );

  // Accumulator: the first partial sum of a window restarts from the bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_acc_last <= 1'b0;
    end else begin
      r_acc_last <= m_valid && m_last;
      if (m_valid) begin
        r_acc <= (m_first ? ACC_W'(r_bias) : r_acc) + ACC_W'(m_psum);
      end
    end
  end

  assign w_relu = (!r_bypass && r_acc[ACC_W-1]) ? '0 : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOAD;
      r_beat_cnt <= '0;
      r_bypass   <= 1'b0;
      r_z        <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (w_first) begin
              r_bypass <= relu_bypass;
            end
            if (w_last) begin
              r_beat_cnt <= '0;
              r_state    <= DRAIN;
            end else begin
              r_beat_cnt <= r_beat_cnt + BW'(1);
            end
          end
        end
        DRAIN: begin
          // r_acc_last marks the cycle r_acc first holds the complete sum.
          if (r_acc_last) begin
            r_state <= OUT;
            r_z     <= w_relu;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_state <= LOAD;
          end
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_neuron_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_neuron_seq
//  Description : Self-checking bench for conv_neuron_seq against a plain
//                dot-product reference model. A second instance with
//                LANES=4 covers the partial final beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_neuron_seq;

  localparam int WIDTH  = 8;
  localparam int F      = 5;
  localparam int CIN    = 3;
  localparam int LANES  = 5;
  localparam int LANES2 = 4;
  localparam int N      = CIN * F * F;
  localparam int BEATS  = (N + LANES - 1) / LANES;
  localparam int BEATS2 = (N + LANES2 - 1) / LANES2;
  localparam int ACC_W  = 2 * WIDTH + $clog2(N + 1);
  localparam int AW     = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic                       w_we, b_we, w_busy, relu_bypass;
  logic [AW-1:0]              w_addr;
  logic [WIDTH-1:0]           w_data;
  logic [2*WIDTH-1:0]         b_data;
  logic                       in_valid, in_ready, out_valid, out_ready;
  logic [LANES*WIDTH-1:0]     in_data;
  logic [ACC_W-1:0]           z;

  logic                       d2_w_we, d2_b_we, d2_w_busy, d2_relu_bypass;
  logic [AW-1:0]              d2_w_addr;
  logic [WIDTH-1:0]           d2_w_data;
  logic [2*WIDTH-1:0]         d2_b_data;
  logic                       d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [LANES2*WIDTH-1:0]    d2_in_data;
  logic [ACC_W-1:0]           d2_z;

  conv_neuron_seq #(.WIDTH(WIDTH), .F(F), .CIN(CIN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_data(b_data), .w_busy(w_busy), .relu_bypass(relu_bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  conv_neuron_seq #(.WIDTH(WIDTH), .F(F), .CIN(CIN), .LANES(LANES2)) dut2 (
    .clk(clk), .rst(rst), .w_we(d2_w_we), .w_addr(d2_w_addr), .w_data(d2_w_data),
    .b_we(d2_b_we), .b_data(d2_b_data), .w_busy(d2_w_busy), .relu_bypass(d2_relu_bypass),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .z(d2_z)
  );

  int  checks = 0;
  int  errors = 0;
  int  wt [N];
  int  xs [N];
  int  bias;
  time t_first;
  logic [ACC_W-1:0] capq [$];

  // Results handed over on each handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) capq.push_back(z);
  end

  // ---------------- reference model ----------------
  function automatic logic [ACC_W-1:0] model(input bit bypass);
    int s;
    s = bias;
    for (int i = 0; i < N; i++) s += wt[i] * xs[i];
    if (!bypass && s < 0) s = 0;
    return ACC_W'(s);
  endfunction

  function automatic int rnd_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_all();
    for (int i = 0; i < N; i++) begin
      wt[i] = rnd_s8();
      xs[i] = rnd_s8();
    end
    bias = rnd_s16();
  endtask

  // Weight and bias written together on the first cycle.
  task automatic load_params();
    for (int i = 0; i < N; i++) begin
      w_we = 1'b1; w_addr = AW'(i); w_data = WIDTH'(wt[i]);
      b_we = (i == 0); b_data = (2*WIDTH)'(bias);
      tick();
    end
    w_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic send_beats(input int nb, input bit bypass, input bit gaps,
                            input bit poke, output bit to);
    int guard;
    int idx;
    to = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      in_valid    = 1'b1;
      relu_bypass = (b == 0) ? bypass : !bypass;
      for (int k = 0; k < LANES; k++) begin
        idx = b * LANES + k;
        in_data[k*WIDTH +: WIDTH] = (idx < N) ? WIDTH'(xs[idx]) : WIDTH'($urandom);
      end
      if (poke && b == 3) begin
        w_we = 1'b1; w_addr = '0; w_data = WIDTH'(wt[0] + 1);
        b_we = 1'b1; b_data = (2*WIDTH)'(bias + 5);
      end
      guard = 0;
      while (!in_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (!in_ready) to = 1'b1;
      tick();
      if (b == 0) t_first = $time;
      w_we = 1'b0; b_we = 1'b0;
    end
    in_valid    = 1'b0;
    relu_bypass = 1'b0;
  endtask

  task automatic wait_out(output bit to);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    to = !out_valid;
  endtask

  task automatic do_window(input bit bypass, input bit gaps,
                           output logic [ACC_W-1:0] zv, output bit to);
    bit t1, t2;
    send_beats(BEATS, bypass, gaps, 1'b0, t1);
    wait_out(t2);
    to = t1 | t2;
    zv = z;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic d2_load();
    for (int i = 0; i < N; i++) begin
      d2_w_we = 1'b1; d2_w_addr = AW'(i); d2_w_data = WIDTH'(wt[i]);
      d2_b_we = (i == 0); d2_b_data = (2*WIDTH)'(bias);
      tick();
    end
    d2_w_we = 1'b0; d2_b_we = 1'b0;
  endtask

  task automatic d2_window(input logic [WIDTH-1:0] fill,
                           output logic [ACC_W-1:0] zv, output bit to);
    int guard;
    int idx;
    to = 1'b0;
    for (int b = 0; b < BEATS2; b++) begin
      d2_in_valid = 1'b1;
      for (int k = 0; k < LANES2; k++) begin
        idx = b * LANES2 + k;
        d2_in_data[k*WIDTH +: WIDTH] = (idx < N) ? WIDTH'(xs[idx]) : fill;
      end
      guard = 0;
      while (!d2_in_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (!d2_in_ready) to = 1'b1;
      tick();
    end
    d2_in_valid = 1'b0;
    guard = 0;
    while (!d2_out_valid && guard < 100) begin
      tick();
      guard++;
    end
    if (!d2_out_valid) to = 1'b1;
    zv = d2_z;
    d2_out_ready = 1'b1;
    tick();
    d2_out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (z !== '0) begin errors++; $display("FAIL reset_z: got %0d want 0", $signed(z)); end
    checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL reset_w_busy: got %b want 0", w_busy); end
    checks++; if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL reset_d2_in_ready: got %b want 1", d2_in_ready); end
  endtask

  task automatic test_all_ones();
    bit to;
    logic [ACC_W-1:0] ez;
    for (int i = 0; i < N; i++) begin wt[i] = 1; xs[i] = 1; end
    bias = 0;
    ez   = model(1'b0);
    load_params();
    send_beats(BEATS, 1'b0, 1'b0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL ones_accept_timeout: got timeout want accept"); end
    checks++; if (in_ready !== 1'b0 || w_busy !== 1'b1) begin errors++; $display("FAIL ones_drain_flags: got in_ready=%b w_busy=%b want 0/1", in_ready, w_busy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_latency_early: got out_valid=%b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_latency: got out_valid=%b want 1", out_valid); end
    checks++; if (z !== ez) begin errors++; $display("FAIL ones_z: got %0d want %0d", $signed(z), $signed(ez)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || w_busy !== 1'b0) begin errors++; $display("FAIL ones_after_handshake: got in_ready=%b out_valid=%b w_busy=%b want 1/0/0", in_ready, out_valid, w_busy); end
  endtask

  task automatic test_negative_sum();
    bit to;
    logic [ACC_W-1:0] zv, ez;
    for (int i = 0; i < N; i++) begin wt[i] = -1; xs[i] = 1; end
    bias = 10;
    load_params();
    ez = model(1'b0);
    do_window(1'b0, 1'b0, zv, to);
    checks++; if (to || zv !== ez) begin errors++; $display("FAIL neg_relu: got %0d timeout=%b want %0d", $signed(zv), to, $signed(ez)); end
    ez = model(1'b1);
    do_window(1'b1, 1'b0, zv, to);
    checks++; if (to || zv !== ez) begin errors++; $display("FAIL neg_bypass: got %0d timeout=%b want %0d", $signed(zv), to, $signed(ez)); end
  endtask

  task automatic test_extreme();
    bit to;
    logic [ACC_W-1:0] zv, ez;
    for (int i = 0; i < N; i++) begin wt[i] = -128; xs[i] = -128; end
    bias = 32767;
    load_params();
    ez = model(1'b0);
    do_window(1'b0, 1'b0, zv, to);
    checks++; if (to || zv !== ez) begin errors++; $display("FAIL extreme: got %0d timeout=%b want %0d", $signed(zv), to, $signed(ez)); end
  endtask

  task automatic test_random();
    bit to, byp;
    logic [ACC_W-1:0] zv, ez;
    for (int r = 0; r < 6; r++) begin
      randomize_all();
      byp = 1'($urandom_range(0, 1));
      load_params();
      ez = model(byp);
      do_window(byp, 1'b1, zv, to);
      checks++; if (to || zv !== ez) begin errors++; $display("FAIL random_%0d: got %0d timeout=%b want %0d", r, $signed(zv), to, $signed(ez)); end
    end
  endtask

  task automatic test_backpressure();
    bit t1, t2;
    logic [ACC_W-1:0] zs, zv, ez;
    randomize_all();
    load_params();
    ez = model(1'b0);
    send_beats(BEATS, 1'b0, 1'b1, 1'b1, t1);
    wait_out(t2);
    checks++; if (t1 || t2) begin errors++; $display("FAIL bp_timeout: got timeout want result"); end
    zs = z;
    w_we = 1'b1; w_addr = AW'(1); w_data = WIDTH'(wt[1] + 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (z !== zs || out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got z=%0d ov=%b ir=%b want z=%0d ov=1 ir=0", c, $signed(z), out_valid, in_ready, $signed(zs)); end
    end
    w_we = 1'b0;
    checks++; if (z !== ez) begin errors++; $display("FAIL bp_z: got %0d want %0d", $signed(z), $signed(ez)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) xs[i] = rnd_s8();
    ez = model(1'b0);
    do_window(1'b0, 1'b0, zv, t1);
    checks++; if (t1 || zv !== ez) begin errors++; $display("FAIL bp_dropped_writes: got %0d timeout=%b want %0d", $signed(zv), t1, $signed(ez)); end
  endtask

  task automatic test_back_to_back();
    bit t1, t2;
    time ta, tb;
    int g;
    logic [ACC_W-1:0] ea, eb;
    randomize_all();
    load_params();
    capq.delete();
    out_ready = 1'b1;
    ea = model(1'b0);
    send_beats(BEATS, 1'b0, 1'b0, 1'b0, t1);
    ta = t_first;
    for (int i = 0; i < N; i++) xs[i] = rnd_s8();
    eb = model(1'b1);
    send_beats(BEATS, 1'b1, 1'b0, 1'b0, t2);
    tb = t_first;
    g = 0;
    while (capq.size() < 2 && g < 100) begin
      tick();
      g++;
    end
    out_ready = 1'b0;
    checks++; if (t1 || t2) begin errors++; $display("FAIL b2b_timeout: got timeout want accept"); end
    checks++; if (tb - ta != time'((BEATS + 3) * 10)) begin errors++; $display("FAIL b2b_period: got %0t want %0d", tb - ta, (BEATS + 3) * 10); end
    checks++;
    if (capq.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d results want 2", capq.size());
    end else if (capq[0] !== ea || capq[1] !== eb) begin
      errors++; $display("FAIL b2b_values: got %0d,%0d want %0d,%0d", $signed(capq[0]), $signed(capq[1]), $signed(ea), $signed(eb));
    end
  endtask

  task automatic test_reset_mid_window();
    bit to;
    logic [ACC_W-1:0] zv, ez;
    for (int i = 0; i < N; i++) begin wt[i] = 1; xs[i] = 1; end
    bias = 0;
    load_params();
    for (int i = 0; i < N; i++) xs[i] = rnd_s8();
    send_beats(7, 1'b1, 1'b0, 1'b0, to);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || w_busy !== 1'b0) begin errors++; $display("FAIL midrst_state: got ir=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, w_busy); end
    for (int i = 0; i < N; i++) xs[i] = 1;
    ez = model(1'b0);
    do_window(1'b0, 1'b0, zv, to);
    checks++; if (to || zv !== ez) begin errors++; $display("FAIL midrst_z: got %0d timeout=%b want %0d", $signed(zv), to, $signed(ez)); end
  endtask

  task automatic test_partial_last_beat();
    bit ta, tb;
    logic [ACC_W-1:0] za, zb, ez;
    randomize_all();
    d2_load();
    ez = model(1'b0);
    d2_window(8'd127, za, ta);
    d2_window(8'd0, zb, tb);
    checks++; if (ta || za !== ez) begin errors++; $display("FAIL partial_fill127: got %0d timeout=%b want %0d", $signed(za), ta, $signed(ez)); end
    checks++; if (tb || zb !== ez) begin errors++; $display("FAIL partial_fill0: got %0d timeout=%b want %0d", $signed(zb), tb, $signed(ez)); end
  endtask

  initial begin
    rst = 1'b1;
    w_we = 1'b0; b_we = 1'b0; w_addr = '0; w_data = '0; b_data = '0;
    relu_bypass = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    d2_w_we = 1'b0; d2_b_we = 1'b0; d2_w_addr = '0; d2_w_data = '0; d2_b_data = '0;
    d2_relu_bypass = 1'b0; d2_in_valid = 1'b0; d2_in_data = '0; d2_out_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_negative_sum();
    test_extreme();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_window();
    test_partial_last_beat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
